// File: rtl/bsg_nonsynth_manycore_fifo_mem_responder.sv
// bsg_nonsynth_manycore_fifo_mem_responder
//   Word-memory responder on the aligned FIFO side of a manycore endpoint.
//   Services load, store, amoswap and amoadd requests one at a time and
//   returns exactly one response packet per accepted request, in order.
// Ports:
//   clk_i                 clock
//   reset_i               synchronous active-high reset (memory not cleared)
//   mc_req_i/_v_i/_ready_o        request packet, valid/ready handshake
//   endpoint_rsp_o/_v_o/_ready_i  response packet, valid/ready handshake
//   busy_o                high whenever a request is in flight
//   err_count_o           saturating count of errored requests
module bsg_nonsynth_manycore_fifo_mem_responder #(
    parameter int fifo_width_p      = 128,
    parameter int data_width_p      = 32,
    parameter int els_p             = 1024,
    parameter int err_count_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fifo_width_p-1:0]      mc_req_i,
    input  logic                         mc_req_v_i,
    output logic                         mc_req_ready_o,
    output logic [fifo_width_p-1:0]      endpoint_rsp_o,
    output logic                         endpoint_rsp_v_o,
    input  logic                         endpoint_rsp_ready_i,
    output logic                         busy_o,
    output logic [err_count_width_p-1:0] err_count_o
);

    localparam int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int mask_width_lp = data_width_p / 8;

    localparam logic [7:0] op_ld_lp      = 8'd0;
    localparam logic [7:0] op_st_lp      = 8'd1;
    localparam logic [7:0] op_amoswap_lp = 8'd2;
    localparam logic [7:0] op_amoadd_lp  = 8'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;

    state_e state_r, state_n;

    logic [data_width_p-1:0]  data_r;
    logic [lg_els_lp-1:0]     idx_r;
    logic [7:0]               op_r;
    logic [mask_width_lp-1:0] mask_r;
    logic [7:0]               reg_id_r, src_y_r, src_x_r;
    logic                     err_r;

    logic [data_width_p-1:0]  mem [els_p];
    logic [data_width_p-1:0]  rd_data_r;

    logic                      mem_re, mem_we;
    logic [mask_width_lp-1:0]  mem_be;
    logic [data_width_p-1:0]   mem_wdata;
    logic [fifo_width_p-1:0]   rsp_r, rsp_n;
    logic [err_count_width_p-1:0] err_cnt_r;

    logic accept, req_err;

    assign accept  = (state_r == IDLE) && mc_req_v_i;
    // Address is checked against the full 32-bit field so out-of-range
    // requests never alias onto a valid word.
    assign req_err = (mc_req_i[63:32] >= 32'(els_p)) || (mc_req_i[71:64] > op_amoadd_lp);

    logic unused_bits;
    assign unused_bits = ^{mc_req_i[79:76], mc_req_i[fifo_width_p-1:104]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            rsp_r     <= '0;
            err_cnt_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == CAPTURE)
                rsp_r <= rsp_n;
            if (accept && req_err && (err_cnt_r != '1))
                err_cnt_r <= err_cnt_r + err_count_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            data_r   <= mc_req_i[data_width_p-1:0];
            idx_r    <= mc_req_i[32 +: lg_els_lp];
            op_r     <= mc_req_i[71:64];
            mask_r   <= mc_req_i[72 +: mask_width_lp];
            reg_id_r <= mc_req_i[87:80];
            src_y_r  <= mc_req_i[95:88];
            src_x_r  <= mc_req_i[103:96];
            err_r    <= req_err;
        end
    end

    // Single-port synchronous RAM: read in ACCESS, atomic write-back in CAPTURE.
    always_ff @(posedge clk_i) begin
        if (mem_re)
            rd_data_r <= mem[idx_r];
        if (mem_we) begin
            for (int unsigned i = 0; i < mask_width_lp; i++) begin
                if (mem_be[i])
                    mem[idx_r][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n   = state_r;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = data_r;
        rsp_n     = '0;

        case (state_r)
            IDLE: begin
                if (mc_req_v_i)
                    state_n = ACCESS;
            end
            ACCESS: begin
                state_n = CAPTURE;
                if (!err_r) begin
                    if (op_r == op_st_lp) begin
                        mem_we = 1'b1;
                        mem_be = mask_r;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                state_n = RESP;
                if (!err_r && (op_r == op_amoswap_lp)) begin
                    mem_we = 1'b1;
                    mem_be = '1;
                end else if (!err_r && (op_r == op_amoadd_lp)) begin
                    mem_we    = 1'b1;
                    mem_be    = '1;
                    mem_wdata = rd_data_r + data_r;
                end
            end
            RESP: begin
                if (endpoint_rsp_ready_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (!err_r && (op_r != op_st_lp))
            rsp_n[data_width_p-1:0] = rd_data_r;
        rsp_n[39:32] = reg_id_r;
        rsp_n[47:40] = err_r ? 8'd2 : ((op_r == op_st_lp) ? 8'd1 : 8'd0);
        rsp_n[55:48] = src_y_r;
        rsp_n[63:56] = src_x_r;
    end

    assign mc_req_ready_o   = (state_r == IDLE);
    assign endpoint_rsp_v_o = (state_r == RESP);
    assign busy_o           = (state_r != IDLE);
    assign endpoint_rsp_o   = rsp_r;
    assign err_count_o      = err_cnt_r;

    logic unused_op;
    assign unused_op = (op_ld_lp == 8'd0);

endmodule

// File: tb/tb_bsg_nonsynth_manycore_fifo_mem_responder.sv
// Directed bench for bsg_nonsynth_manycore_fifo_mem_responder: loads,
// masked stores, atomics, back-pressure, error requests and mid-flight reset.
module tb_bsg_nonsynth_manycore_fifo_mem_responder;

    localparam int W   = 128;
    localparam int ELS = 1024;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [W-1:0]  mc_req_i;
    logic          mc_req_v_i;
    logic          mc_req_ready_o;
    logic [W-1:0]  endpoint_rsp_o;
    logic          endpoint_rsp_v_o;
    logic          endpoint_rsp_ready_i;
    logic          busy_o;
    logic [15:0]   err_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_nonsynth_manycore_fifo_mem_responder #(
        .fifo_width_p(W), .data_width_p(32), .els_p(ELS), .err_count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .mc_req_i(mc_req_i), .mc_req_v_i(mc_req_v_i), .mc_req_ready_o(mc_req_ready_o),
        .endpoint_rsp_o(endpoint_rsp_o), .endpoint_rsp_v_o(endpoint_rsp_v_o),
        .endpoint_rsp_ready_i(endpoint_rsp_ready_i),
        .busy_o(busy_o), .err_count_o(err_count_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [3:0] mask,
                                            input logic [7:0] rid, input logic [7:0] y,
                                            input logic [7:0] x);
        logic [W-1:0] r;
        r = '0;
        r[31:0]    = data;
        r[63:32]   = addr;
        r[71:64]   = op;
        r[75:72]   = mask;
        r[79:76]   = 4'hA;          // ignored bits carry junk
        r[87:80]   = rid;
        r[95:88]   = y;
        r[103:96]  = x;
        r[127:104] = 24'h5A5A5A;
        return r;
    endfunction

    // One full transaction: accept, latency check, optional back-pressure, completion.
    task automatic txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask,
                       input logic [7:0] rid, input logic [7:0] y, input logic [7:0] x,
                       input logic [7:0] etype, input logic [31:0] edata,
                       input bit chk_data, input int hold);
        logic [W-1:0] held;
        @(negedge clk);
        chk({tag, ".ready"}, 128'(mc_req_ready_o), 128'(1));
        mc_req_i   = mk_req(op, addr, data, mask, rid, y, x);
        mc_req_v_i = 1'b1;
        @(posedge clk); #1;
        mc_req_v_i = 1'b0;
        mc_req_i   = '0;
        @(negedge clk);
        chk({tag, ".access"}, 128'({endpoint_rsp_v_o, busy_o, mc_req_ready_o}), 128'(3'b010));
        @(negedge clk);
        chk({tag, ".capture"}, 128'(endpoint_rsp_v_o), 128'(0));
        @(negedge clk);
        chk({tag, ".rsp_v"}, 128'(endpoint_rsp_v_o), 128'(1));
        chk({tag, ".hdr"}, 128'(endpoint_rsp_o[W-1:32]), 128'({64'b0, x, y, etype, rid}));
        if (chk_data)
            chk({tag, ".data"}, 128'(endpoint_rsp_o[31:0]), 128'(edata));
        held = endpoint_rsp_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold"}, 128'({endpoint_rsp_v_o, mc_req_ready_o, endpoint_rsp_o}),
                128'({1'b1, 1'b0, held}));
        end
        endpoint_rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        endpoint_rsp_ready_i = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, 128'({endpoint_rsp_v_o, busy_o, mc_req_ready_o}), 128'(3'b001));
    endtask

    initial begin
        reset_i = 1'b1;
        mc_req_i = '0;
        mc_req_v_i = 1'b0;
        endpoint_rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("reset.ctl", 128'({mc_req_ready_o, endpoint_rsp_v_o, busy_o}), 128'(3'b100));
        chk("reset.rsp", 128'(endpoint_rsp_o), 128'(0));
        chk("reset.err", 128'(err_count_o), 128'(0));

        // store then load
        txn("st5",  8'd1, 32'd5, 32'hA5A5A5A5, 4'hF, 8'h12, 8'd3, 8'd4, 8'd1, 32'h0, 1'b0, 0);
        txn("ld5",  8'd0, 32'd5, 32'h0,        4'h0, 8'h21, 8'd6, 8'd9, 8'd0, 32'hA5A5A5A5, 1'b1, 0);
        // mask 0 writes nothing but still acks
        txn("st5m0", 8'd1, 32'd5, 32'h0,       4'h0, 8'h01, 8'd1, 8'd1, 8'd1, 32'h0, 1'b0, 0);
        txn("ld5b", 8'd0, 32'd5, 32'h0,        4'hF, 8'h02, 8'd1, 8'd1, 8'd0, 32'hA5A5A5A5, 1'b1, 0);
        // byte-masked store
        txn("st7",  8'd1, 32'd7, 32'h11223344, 4'hF, 8'h03, 8'd0, 8'd0, 8'd1, 32'h0, 1'b0, 0);
        txn("st7m5", 8'd1, 32'd7, 32'hFFFFFFFF, 4'h5, 8'h04, 8'd0, 8'd0, 8'd1, 32'h0, 1'b0, 0);
        txn("ld7",  8'd0, 32'd7, 32'h0,        4'h0, 8'h05, 8'd2, 8'd7, 8'd0, 32'h11FF33FF, 1'b1, 0);
        // atomics on word 2
        txn("st2",  8'd1, 32'd2, 32'hFFFFFFFE, 4'hF, 8'h06, 8'd0, 8'd0, 8'd1, 32'h0, 1'b0, 0);
        txn("amoadd", 8'd3, 32'd2, 32'd3,      4'h0, 8'h07, 8'd1, 8'd2, 8'd0, 32'hFFFFFFFE, 1'b1, 0);
        txn("amoswap", 8'd2, 32'd2, 32'h55,    4'h0, 8'h08, 8'd1, 8'd2, 8'd0, 32'h00000001, 1'b1, 0);
        txn("ld2",  8'd0, 32'd2, 32'h0,        4'h0, 8'h09, 8'd1, 8'd2, 8'd0, 32'h00000055, 1'b1, 0);
        // back-pressure for 10 cycles
        txn("hold", 8'd0, 32'd7, 32'h0,        4'h0, 8'h0A, 8'd4, 8'd5, 8'd0, 32'h11FF33FF, 1'b1, 10);
        // errors: out-of-range address, illegal op that would otherwise overwrite word 5
        txn("err_addr", 8'd0, 32'(ELS), 32'h0, 4'h0, 8'h0B, 8'd1, 8'd1, 8'd2, 32'h0, 1'b1, 0);
        txn("err_op", 8'd7, 32'd5, 32'hDEADBEEF, 4'hF, 8'h0C, 8'd1, 8'd1, 8'd2, 32'h0, 1'b1, 0);
        chk("err_count", 128'(err_count_o), 128'(2));
        txn("ld5c", 8'd0, 32'd5, 32'h0,        4'h0, 8'h0D, 8'd1, 8'd1, 8'd0, 32'hA5A5A5A5, 1'b1, 0);

        // reset during CAPTURE of a load drops the transaction
        @(negedge clk);
        mc_req_i   = mk_req(8'd0, 32'd2, 32'h0, 4'h0, 8'h0E, 8'd1, 8'd1);
        mc_req_v_i = 1'b1;
        @(posedge clk); #1;
        mc_req_v_i = 1'b0;
        @(negedge clk);            // ACCESS
        @(negedge clk);            // CAPTURE
        chk("rst.busy", 128'(busy_o), 128'(1));
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst.ctl", 128'({mc_req_ready_o, endpoint_rsp_v_o, busy_o}), 128'(3'b100));
        chk("rst.rsp", 128'(endpoint_rsp_o), 128'(0));
        chk("rst.err", 128'(err_count_o), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.norsp", 128'(endpoint_rsp_v_o), 128'(0));
        end
        txn("after_rst", 8'd0, 32'd7, 32'h0, 4'h0, 8'h0F, 8'd3, 8'd3, 8'd0, 32'h11FF33FF, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
